// File: rtl/spi_slv16.sv
// SPI mode-0 responder: shifts a preloaded word out on MISO while capturing MOSI.
// Optional frame-length checking with frm_err is enabled by defining SPI_SLV_FRAME_ERR_EN.
module spi_slv16 #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rdy,
  input  logic             clr_rdy,
`ifdef SPI_SLV_FRAME_ERR_EN
  output logic             frm_err,
`endif
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state, next_state;

  // Handshake: wrt and clr_rdy are single-cycle strobes; rdy stays high
  // from one clk after frame end until clr_rdy or the next frame start.
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_hist, sclk_hist, mosi_d;
  logic ss_fall_e, ss_rise_e, sclk_rise_e, sclk_fall_e;

  logic [WIDTH-1:0] tx_buf, shft_reg, shft_next;
  logic [CW-1:0]    bit_cnt;
  logic             mosi_smpl, pend, rdy_set;

  logic ss_s, sclk_s, mosi_s;
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchronizers, history flops and registered edge events. SS_n resets
  // high so leaving reset never looks like a select edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync     <= '1;
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      ss_hist     <= 1'b1;
      sclk_hist   <= 1'b0;
      mosi_d      <= 1'b0;
      ss_fall_e   <= 1'b0;
      ss_rise_e   <= 1'b0;
      sclk_rise_e <= 1'b0;
      sclk_fall_e <= 1'b0;
    end else begin
      ss_sync     <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_hist     <= ss_s;
      sclk_hist   <= sclk_s;
      mosi_d      <= mosi_s;
      ss_fall_e   <= ss_hist & ~ss_s;
      ss_rise_e   <= ~ss_hist & ss_s;
      sclk_rise_e <= ~sclk_hist & sclk_s;
      sclk_fall_e <= sclk_hist & ~sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ss_fall_e) next_state = SHIFT;
      SHIFT:   if (ss_rise_e) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A rise not yet followed by a fall still owes one shift at frame end.
  assign shft_next = pend ? {shft_reg[WIDTH-2:0], mosi_smpl} : shft_reg;
  assign MISO      = (state == SHIFT) ? shft_reg[WIDTH-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf    <= '0;
      shft_reg  <= '0;
      bit_cnt   <= '0;
      mosi_smpl <= 1'b0;
      pend      <= 1'b0;
      rd_data   <= '0;
      rdy       <= 1'b0;
      rdy_set   <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
      frm_err   <= 1'b0;
`endif
    end else begin
      rdy_set <= 1'b0;
      if (wrt) tx_buf <= tx_data;
      if (rdy_set)      rdy <= 1'b1;
      else if (clr_rdy) rdy <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
      if (clr_rdy) frm_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ss_fall_e) begin
            shft_reg <= wrt ? tx_data : tx_buf;
            bit_cnt  <= '0;
            pend     <= 1'b0;
            if (!rdy_set) rdy <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
            frm_err  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (ss_rise_e) begin
            shft_reg <= shft_next;
            pend     <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
            if (bit_cnt != FULL) begin
              frm_err <= 1'b1;
            end else begin
              rd_data <= shft_next;
              rdy_set <= 1'b1;
            end
`else
            rd_data <= shft_next;
            rdy_set <= 1'b1;
`endif
          end else if (sclk_rise_e) begin
            mosi_smpl <= mosi_d;
            pend      <= 1'b1;
            if (bit_cnt != FULL) bit_cnt <= bit_cnt + 1'b1;
          end else if (sclk_fall_e && pend) begin
            shft_reg <= {shft_reg[WIDTH-2:0], mosi_smpl};
            pend     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slv16.sv
// Directed bench for spi_slv16: a bit-banged SPI master with queued expected
// rd_data / MISO words checked after each frame.
module tb_spi_slv16;

  logic        clk = 1'b0;
  logic        rst, wrt, clr_rdy, SS_n, SCLK, MOSI;
  logic [15:0] tx_data, rd_data;
  logic        rdy, MISO;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic        frm_err;
`endif

  spi_slv16 dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .tx_data (tx_data),
    .rd_data (rd_data),
    .rdy     (rdy),
    .clr_rdy (clr_rdy),
`ifdef SPI_SLV_FRAME_ERR_EN
    .frm_err (frm_err),
`endif
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] miso_q[$];
  logic [15:0] miso_w;
  logic        rdy0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [15:0] v);
    tx_data = v;
    wrt = 1'b1;
    tick(1);
    wrt = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    tick(1);
  endtask

  // 16 clk per SCLK half-period; optional mid-frame wrt, reset, or dropped final fall.
  task automatic frame(input logic [15:0] w, input int nbits, input bit drop_fall,
                       input int wrt_bit, input logic [15:0] wrt_val, input int rst_bit,
                       output logic [15:0] mw, output logic r0);
    mw = '0;
    SS_n = 1'b0;
    tick(16);
    r0 = rdy;
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[15-i];
      if (i == wrt_bit) begin
        tx_data = wrt_val;
        wrt = 1'b1;
        tick(1);
        wrt = 1'b0;
        tick(7);
      end else begin
        tick(8);
      end
      mw[15-i] = MISO;
      SCLK = 1'b1;
      tick(16);
      if (rst_bit == i + 1) begin
        rst = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(4);
        return;
      end
      if (!(drop_fall && i == nbits - 1)) begin
        SCLK = 1'b0;
        tick(8);
      end
    end
    tick(8);
    SS_n = 1'b1;
    tick(16);
    SCLK = 1'b0;
    MOSI = 1'b0;
    tick(20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; wrt = 1'b0; clr_rdy = 1'b0; tx_data = '0;
    SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_rdy", {15'b0, rdy}, 16'h0000);
    check("reset_miso", {15'b0, MISO}, 16'h0000);
`ifdef SPI_SLV_FRAME_ERR_EN
    check("reset_frm_err", {15'b0, frm_err}, 16'h0000);
`endif

    // Basic frame
    load_tx(16'hA5C3);
    exp_q.push_back(16'h1234); miso_q.push_back(16'hA5C3);
    frame(16'h1234, 16, 1'b0, -1, 16'h0, -1, miso_w, rdy0);
    check("t1_miso", miso_w, miso_q.pop_front());
    check("t1_rd_data", rd_data, exp_q.pop_front());
    check("t1_rdy", {15'b0, rdy}, 16'h0001);
    pulse_clr();
    check("t1_rdy_clr", {15'b0, rdy}, 16'h0000);

    // Back-to-back frames, no clr_rdy
    exp_q.push_back(16'hFFFF); miso_q.push_back(16'hA5C3);
    frame(16'hFFFF, 16, 1'b0, -1, 16'h0, -1, miso_w, rdy0);
    check("t2a_miso", miso_w, miso_q.pop_front());
    check("t2a_rd_data", rd_data, exp_q.pop_front());
    check("t2a_rdy", {15'b0, rdy}, 16'h0001);
    exp_q.push_back(16'h0001); miso_q.push_back(16'hA5C3);
    frame(16'h0001, 16, 1'b0, -1, 16'h0, -1, miso_w, rdy0);
    check("t2b_rdy_at_start", {15'b0, rdy0}, 16'h0000);
    check("t2b_miso", miso_w, miso_q.pop_front());
    check("t2b_rd_data", rd_data, exp_q.pop_front());
    check("t2b_rdy", {15'b0, rdy}, 16'h0001);

    // wrt during a frame only affects the next frame
    pulse_clr();
    load_tx(16'h0F0F);
    exp_q.push_back(16'h3C3C); miso_q.push_back(16'h0F0F);
    frame(16'h3C3C, 16, 1'b0, 4, 16'hBEEF, -1, miso_w, rdy0);
    check("t3a_miso", miso_w, miso_q.pop_front());
    check("t3a_rd_data", rd_data, exp_q.pop_front());
    exp_q.push_back(16'hC3C3); miso_q.push_back(16'hBEEF);
    frame(16'hC3C3, 16, 1'b0, -1, 16'h0, -1, miso_w, rdy0);
    check("t3b_miso", miso_w, miso_q.pop_front());
    check("t3b_rd_data", rd_data, exp_q.pop_front());

    // Final SCLK fall omitted
    pulse_clr();
    exp_q.push_back(16'h8001); miso_q.push_back(16'hBEEF);
    frame(16'h8001, 16, 1'b1, -1, 16'h0, -1, miso_w, rdy0);
    check("t4_miso", miso_w, miso_q.pop_front());
    check("t4_rd_data", rd_data, exp_q.pop_front());
    check("t4_rdy", {15'b0, rdy}, 16'h0001);

    // Reset mid-frame, then a clean frame (tx buffer back to zero)
    pulse_clr();
    frame(16'h5A5A, 16, 1'b0, -1, 16'h0, 8, miso_w, rdy0);
    check("t5_rst_rdy", {15'b0, rdy}, 16'h0000);
    check("t5_rst_rd_data", rd_data, 16'h0000);
    check("t5_rst_miso", {15'b0, MISO}, 16'h0000);
    exp_q.push_back(16'h5A5A); miso_q.push_back(16'h0000);
    frame(16'h5A5A, 16, 1'b0, -1, 16'h0, -1, miso_w, rdy0);
    check("t5_miso", miso_w, miso_q.pop_front());
    check("t5_rd_data", rd_data, exp_q.pop_front());
    check("t5_rdy", {15'b0, rdy}, 16'h0001);
    check("t5_idle_miso", {15'b0, MISO}, 16'h0000);

    // Short 8-bit frame
    pulse_clr();
    load_tx(16'h1234);
    miso_q.push_back(16'h1200);
`ifdef SPI_SLV_FRAME_ERR_EN
    exp_q.push_back(16'h5A5A);
`else
    exp_q.push_back(16'h34A7);
`endif
    frame(16'hA700, 8, 1'b0, -1, 16'h0, -1, miso_w, rdy0);
    check("t6_miso", miso_w, miso_q.pop_front());
    check("t6_rd_data", rd_data, exp_q.pop_front());
`ifdef SPI_SLV_FRAME_ERR_EN
    check("t6_frm_err", {15'b0, frm_err}, 16'h0001);
    check("t6_rdy", {15'b0, rdy}, 16'h0000);
    pulse_clr();
    check("t6_frm_err_clr", {15'b0, frm_err}, 16'h0000);
`else
    check("t6_rdy", {15'b0, rdy}, 16'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
